i4004_bus_master: RTL

// - MCS-4 bus initiator: the CPU end of the bus that the i4001 ROM/IO and i4002 models respond to.
// - Generates the two-phase clk1/clk2, the sync strobe and the 8-phase instruction cycle (A1 A2 A3 M1 M2 X1 X2 X3).
// - Drives the 12-bit fetch address as three nibbles in A1..A3 and samples OPR/OPA in M1/M2.
// - Drives or samples the X2 data nibble (SRC/WRR vs RDR) and drives cmrom.
// - Sits between a CPU datapath/testbench host and the shared data bus of the ROM models.
//

---
 rtl/i4004_bus_if.sv | 21 ++
 rtl/i4004_bus_master.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/i4004_bus_if.sv
// MCS-4 shared bus: two-phase clocks, sync, cmrom and the 4-bit data nibble.
// data_out/data_dir come from the initiator; data_in is the bus nibble seen from the pads.
interface i4004_bus_if;
  logic       clk1;
  logic       clk2;
  logic       sync;
  logic       cmrom;
  logic [3:0] data_out;
  logic       data_dir;
  logic [3:0] data_in;

  modport master (
    output clk1, clk2, sync, cmrom, data_out, data_dir,
    input  data_in
  );

  modport slave (
    input  clk1, clk2, sync, cmrom, data_out, data_dir,
    output data_in
  );
endinterface

// File: rtl/i4004_bus_master.sv
// MCS-4 bus initiator: generates clk1/clk2/sync and the 8-phase instruction cycle,
// drives the fetch address and X2 nibble, and samples OPR/OPA/X2 read data.
module i4004_bus_master #(
  parameter int unsigned TICK_DIV = 1
) (
  input  logic               sysclk,
  input  logic               poc_n,
  input  logic               run,
  input  logic [11:0]        addr,
  input  logic               m2_cmrom,
  input  logic               x2_cmrom,
  input  logic               x2_drive,
  input  logic [3:0]         x2_wdata,
  i4004_bus_if.master        bus,
  output logic               cyc_start,
  output logic [3:0]         opr,
  output logic [3:0]         opa,
  output logic               instr_valid,
  output logic [3:0]         x2_rdata,
  output logic               x2_rvalid
);

  typedef enum logic [2:0] {StA1, StA2, StA3, StM1, StM2, StX1, StX2, StX3} phase_e;

  localparam logic [7:0] PreLast = 8'(TICK_DIV - 1);

  phase_e      phase_q, phase_d;
  logic [1:0]  tick_q, tick_d;
  logic [7:0]  pre_q, pre_d;
  logic        tick_end, sample, start;

  logic [11:0] addr_q, addr_d;
  logic        m2c_q, m2c_d, x2c_q, x2c_d, drv_q, drv_d;
  logic [3:0]  wd_q, wd_d;

  logic        clk1_q, clk1_d, clk2_q, clk2_d, sync_q, sync_d, cmrom_q, cmrom_d;
  logic        dir_q, dir_d, cyc_q, cyc_d, iv_q, iv_d, xv_q, xv_d;
  logic [3:0]  dout_q, dout_d, opr_q, opr_d, opa_q, opa_d, xr_q, xr_d;

  always_comb begin
    tick_end = (pre_q == PreLast);
    pre_d    = tick_end ? 8'd0 : pre_q + 8'd1;
    tick_d   = tick_end ? tick_q + 2'd1 : tick_q;
    phase_d  = phase_q;
    start    = 1'b0;
    if (tick_end && tick_q == 2'd3) begin
      unique case (phase_q)
        StA1: phase_d = StA2;
        StA2: phase_d = StA3;
        StA3: phase_d = StM1;
        StM1: phase_d = StM2;
        StM2: phase_d = StX1;
        StX1: phase_d = StX2;
        StX2: phase_d = StX3;
        StX3: begin
          if (run) begin
            phase_d = StA1;
            start   = 1'b1;
          end
        end
        default: phase_d = StX3;
      endcase
    end

    addr_d = start ? addr     : addr_q;
    m2c_d  = start ? m2_cmrom : m2c_q;
    x2c_d  = start ? x2_cmrom : x2c_q;
    drv_d  = start ? x2_drive : drv_q;
    wd_d   = start ? x2_wdata : wd_q;

    // Outputs are computed from next state so the registered copies line up with it.
    clk1_d  = (tick_d == 2'd0);
    clk2_d  = (tick_d == 2'd2);
    sync_d  = (phase_d == StX3);
    cmrom_d = 1'b0;
    dir_d   = 1'b0;
    dout_d  = 4'd0;
    unique case (phase_d)
      StA1: begin dir_d = 1'b1; dout_d = addr_d[3:0]; end
      StA2: begin dir_d = 1'b1; dout_d = addr_d[7:4]; end
      StA3: begin dir_d = 1'b1; dout_d = addr_d[11:8]; cmrom_d = 1'b1; end
      StM2: cmrom_d = m2c_d;
      StX2: begin
        cmrom_d = x2c_d;
        dir_d   = drv_d;
        dout_d  = drv_d ? wd_d : 4'd0;
      end
      default: ;
    endcase

    // Sample on the last sysclk of tick2, i.e. as clk2 falls.
    sample = tick_end && (tick_q == 2'd2);
    cyc_d  = start;
    iv_d   = sample && (phase_q == StM2);
    xv_d   = sample && (phase_q == StX2) && !drv_q;
    opr_d  = (sample && phase_q == StM1) ? bus.data_in : opr_q;
    opa_d  = iv_d ? bus.data_in : opa_q;
    xr_d   = xv_d ? bus.data_in : xr_q;
  end

  always_ff @(posedge sysclk or negedge poc_n) begin
    if (!poc_n) begin
      phase_q <= StX3;
      tick_q  <= 2'd0;
      pre_q   <= 8'd0;
      addr_q  <= 12'd0;
      m2c_q   <= 1'b0;
      x2c_q   <= 1'b0;
      drv_q   <= 1'b0;
      wd_q    <= 4'd0;
      clk1_q  <= 1'b0;
      clk2_q  <= 1'b0;
      sync_q  <= 1'b1;
      cmrom_q <= 1'b0;
      dir_q   <= 1'b0;
      dout_q  <= 4'd0;
      cyc_q   <= 1'b0;
      iv_q    <= 1'b0;
      xv_q    <= 1'b0;
      opr_q   <= 4'd0;
      opa_q   <= 4'd0;
      xr_q    <= 4'd0;
    end else begin
      phase_q <= phase_d;
      tick_q  <= tick_d;
      pre_q   <= pre_d;
      addr_q  <= addr_d;
      m2c_q   <= m2c_d;
      x2c_q   <= x2c_d;
      drv_q   <= drv_d;
      wd_q    <= wd_d;
      clk1_q  <= clk1_d;
      clk2_q  <= clk2_d;
      sync_q  <= sync_d;
      cmrom_q <= cmrom_d;
      dir_q   <= dir_d;
      dout_q  <= dout_d;
      cyc_q   <= cyc_d;
      iv_q    <= iv_d;
      xv_q    <= xv_d;
      opr_q   <= opr_d;
      opa_q   <= opa_d;
      xr_q    <= xr_d;
    end
  end

  assign bus.clk1     = clk1_q;
  assign bus.clk2     = clk2_q;
  assign bus.sync     = sync_q;
  assign bus.cmrom    = cmrom_q;
  assign bus.data_out = dout_q;
  assign bus.data_dir = dir_q;
  assign cyc_start    = cyc_q;
  assign opr          = opr_q;
  assign opa          = opa_q;
  assign instr_valid  = iv_q;
  assign x2_rdata     = xr_q;
  assign x2_rvalid    = xv_q;

endmodule
